// File: rtl/serial_sequence_generator.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first on x,
// repeating it repeat_cnt+1 times with an optional idle gap between passes.
module serial_sequence_generator #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [CNT_W-1:0] repeat_cnt,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP > 1) ? $clog2(GAP + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP, S_DONE} state_t;

  state_t             state_reg, state_next;
  logic [PAT_W-1:0]   pat_reg, pat_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   pass_reg, pass_next;
  logic [GAP_W-1:0]   gap_reg, gap_next;
  logic               load_reg, load_next;
  logic               x_reg, x_next;
  logic               valid_reg, valid_next;
  logic               busy_reg, busy_next;
  logic               done_reg, done_next;
  logic [PAT_W-1:0]   shifted;

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    len_next   = len_reg;
    idx_next   = idx_reg;
    pass_next  = pass_reg;
    gap_next   = gap_reg;
    load_next  = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // load_reg marks the one-cycle latency slot between capture and the
        // first bit; starts seen during that slot are ignored.
        if (load_reg) begin
          if (len_reg == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_SHIFT;
            idx_next   = len_reg - LEN_W'(1);
          end
        end else if (start) begin
          pat_next  = pattern;
          len_next  = (len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : len;
          pass_next = repeat_cnt;
          load_next = 1'b1;
        end
      end
      S_SHIFT: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (idx_reg == '0) begin
          if (pass_reg != '0) begin
            pass_next = pass_reg - CNT_W'(1);
            if (GAP > 0) begin
              state_next = S_GAP;
              gap_next   = GAP_W'((GAP > 0) ? GAP - 1 : 0);
            end else begin
              idx_next = len_reg - LEN_W'(1);
            end
          end else begin
            state_next = S_DONE;
          end
        end else begin
          idx_next = idx_reg - LEN_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          state_next = S_IDLE;
        end else if (gap_reg == '0) begin
          state_next = S_SHIFT;
          idx_next   = len_reg - LEN_W'(1);
        end else begin
          gap_next = gap_reg - GAP_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    shifted    = pat_reg >> idx_next;
    x_next     = (state_next == S_SHIFT) ? shifted[0] : 1'b1;
    valid_next = (state_next == S_SHIFT);
    busy_next  = (state_next != S_IDLE);
    done_next  = (state_next == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      pat_reg   <= '0;
      len_reg   <= '0;
      idx_reg   <= '0;
      pass_reg  <= '0;
      gap_reg   <= '0;
      load_reg  <= 1'b0;
      x_reg     <= 1'b1;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      len_reg   <= len_next;
      idx_reg   <= idx_next;
      pass_reg  <= pass_next;
      gap_reg   <= gap_next;
      load_reg  <= load_next;
      x_reg     <= x_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign x     = x_reg;
  assign valid = valid_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_serial_sequence_generator.sv
// Randomized self-checking bench: one GAP=1 and one GAP=0 instance share the
// stimulus; a per-cycle expected output trace is built from the pattern rules.
module tb_serial_sequence_generator;

  typedef logic [3:0] q4_t[$];
  typedef logic [7:0] q8_t[$];

  logic       clk = 1'b0;
  logic       rst, start, abort;
  logic [7:0] pattern;
  logic [3:0] len, repeat_cnt;
  logic       x_g1, valid_g1, busy_g1, done_g1;
  logic       x_g0, valid_g0, busy_g0, done_g0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_sequence_generator #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(1)) u_gap1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .repeat_cnt(repeat_cnt),
    .x(x_g1), .valid(valid_g1), .busy(busy_g1), .done(done_g1)
  );

  serial_sequence_generator #(.PAT_W(8), .LEN_W(4), .CNT_W(4), .GAP(0)) u_gap0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .pattern(pattern),
    .len(len), .repeat_cnt(repeat_cnt),
    .x(x_g0), .valid(valid_g0), .busy(busy_g0), .done(done_g0)
  );

  // Expected {x,valid,busy,done} per cycle, starting with the output right
  // after the edge that accepts start (still idle), ending with an idle cycle.
  function automatic q4_t build(input logic [7:0] pat, input int l_in, input int rep, input int g);
    q4_t q;
    int l;
    l = (l_in > 8) ? 8 : l_in;
    q.push_back(4'b1000);
    if (l > 0) begin
      for (int p = 0; p <= rep; p++) begin
        if (p > 0)
          for (int j = 0; j < g; j++) q.push_back(4'b1010);
        for (int i = l - 1; i >= 0; i--) q.push_back({pat[i], 3'b110});
      end
    end
    q.push_back(4'b1011);
    q.push_back(4'b1000);
    return q;
  endfunction

  function automatic q4_t cut(input q4_t q_in, input int t, input int kind);
    q4_t q;
    q = q_in;
    if (kind != 0 && t < q.size() - 1 &&
        (kind == 2 || (t > 0 && q[t][1] && !q[t][0]))) begin
      while (q.size() > t + 1) void'(q.pop_back());
      q.push_back(4'b1000);
    end
    return q;
  endfunction

  // Drives one transmission; cut_kind 1 = abort, 2 = reset, at cycle cut_t.
  task automatic run_tx(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                        input bit abort_with_start, input int cut_t, input int cut_kind,
                        input bit stray_en, output q8_t obs, output q8_t exp);
    q4_t e1, e0;
    int  n;
    obs = {};
    exp = {};
    e1 = build(p, int'(l), int'(r), 1);
    e0 = build(p, int'(l), int'(r), 0);
    n  = (e1.size() > e0.size()) ? e1.size() : e0.size();
    if (cut_t < n - 1) begin
      e1 = cut(e1, cut_t, cut_kind);
      e0 = cut(e0, cut_t, cut_kind);
      n  = (e1.size() > e0.size()) ? e1.size() : e0.size();
    end
    for (int t = 0; t < n; t++)
      exp.push_back({(t < e1.size()) ? e1[t] : 4'b1000, (t < e0.size()) ? e0[t] : 4'b1000});

    pattern = p; len = l; repeat_cnt = r;
    start = 1'b1; abort = abort_with_start;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int t = 0; t < n; t++) begin
      obs.push_back({x_g1, valid_g1, busy_g1, done_g1, x_g0, valid_g0, busy_g0, done_g0});
      if (t == n - 1) break;
      pattern = 8'($urandom); len = 4'($urandom); repeat_cnt = 4'($urandom);
      if (stray_en && t >= 1 && t != cut_t && exp[t][5] && exp[t][1])
        start = 1'($urandom_range(0, 1));
      if (t == cut_t && cut_kind == 1) abort = 1'b1;
      if (t == cut_t && cut_kind == 2) rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; rst = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [7:0] got;
    rst = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = 8'hA5; len = 4'd4; repeat_cnt = 4'd0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      got = {x_g1, valid_g1, busy_g1, done_g1, x_g0, valid_g0, busy_g0, done_g0};
      n_cmp++;
      if (got !== 8'b1000_1000) begin
        n_bad++; $display("FAIL reset cyc %0d: got %b want 10001000", c, got);
      end
    end
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      got = {x_g1, valid_g1, busy_g1, done_g1, x_g0, valid_g0, busy_g0, done_g0};
      n_cmp++;
      if (got !== 8'b1000_1000) begin
        n_bad++; $display("FAIL post_reset_idle cyc %0d: got %b want 10001000", c, got);
      end
    end
  endtask

  task automatic test_basic();
    q8_t obs, exp;
    run_tx(8'b0000_0100, 4'd3, 4'd0, 1'b0, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL basic cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_repeat_gap();
    q8_t obs, exp;
    run_tx(8'b1010_0110, 4'd8, 4'd1, 1'b0, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL repeat_gap cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    q8_t obs, exp;
    run_tx(8'b0000_0001, 4'd2, 4'd2, 1'b0, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_boundaries();
    q8_t obs, exp;
    run_tx(8'hFF, 4'd0, 4'd3, 1'b0, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL len_zero cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
    run_tx(8'b1100_1011, 4'd12, 4'd0, 1'b0, -1, 0, 1'b1, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL len_clamp cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
    run_tx(8'b0000_0001, 4'd1, 4'd15, 1'b0, -1, 0, 1'b1, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL max_repeat cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_abort();
    q8_t obs, exp;
    run_tx(8'b1011_0010, 4'd8, 4'd1, 1'b0, 3, 1, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL abort cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
    run_tx(8'b0110_1001, 4'd5, 4'd0, 1'b1, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL abort_restart cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    q8_t obs, exp;
    run_tx(8'b1110_0101, 4'd8, 4'd2, 1'b0, 5, 2, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL reset_mid cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
    run_tx(8'b0011_1010, 4'd6, 4'd0, 1'b0, -1, 0, 1'b0, obs, exp);
    for (int i = 0; i < exp.size(); i++) begin
      n_cmp++;
      if (obs[i] !== exp[i]) begin
        n_bad++; $display("FAIL reset_fresh cyc %0d: got %b want %b", i, obs[i], exp[i]);
      end
    end
  endtask

  task automatic test_random();
    q8_t obs, exp;
    int  kind;
    for (int k = 0; k < 25; k++) begin
      kind = $urandom_range(0, 3);
      run_tx(8'($urandom), 4'($urandom_range(0, 12)), 4'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(1, 20), (kind == 3) ? 0 : kind,
             1'b1, obs, exp);
      for (int i = 0; i < exp.size(); i++) begin
        n_cmp++;
        if (obs[i] !== exp[i]) begin
          n_bad++; $display("FAIL random tx %0d cyc %0d: got %b want %b", k, i, obs[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = '0; len = '0; repeat_cnt = '0;
    test_reset();
    test_basic();
    test_repeat_gap();
    test_back_to_back();
    test_boundaries();
    test_abort();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
